// File: rtl/vend_ctrl.sv
// vend_ctrl: cola vending transaction controller.
// Collects coin credit in half-unit steps, runs the dispenser req/ack
// handshake, and pays out change or refunds one half-unit pulse at a time.
// Optional build macro DSP_TIMEOUT_EN adds a dispenser watchdog that raises
// a sticky po_fault and refunds the full credit when the ack never arrives.
module vend_ctrl #(
  parameter int PRICE       = 4,
  parameter int CREDIT_W    = 3,
  parameter int CHG_GAP     = 8,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int TO_W        = 26
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                pi_money_half,
  input  logic                pi_money_one,
  input  logic                pi_cancel,
  input  logic                pi_dsp_ack,
  output logic                po_dsp_req,
  output logic                po_change,
  output logic                po_reject,
  output logic [CREDIT_W-1:0] po_credit,
  output logic                po_fault
);

  localparam int GAP_W = $clog2(CHG_GAP);

  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [TO_W-1:0]     TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(CHG_GAP - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    COLLECT  = 4'b0010,
    DISPENSE = 4'b0100,
    REFUND   = 4'b1000
  } state_t;

  state_t              state;
  logic [TO_W-1:0]     to_cnt;
  logic [GAP_W-1:0]    chg_cnt;

  logic                coin_in;
  logic [CREDIT_W-1:0] coin_add;
  logic [CREDIT_W-1:0] credit_sum;
  logic [CREDIT_W-1:0] credit_rem;

  // The two coin pulses form a 2-bit value that is already weighted 2/1.
  assign coin_in    = pi_money_one | pi_money_half;
  assign coin_add   = CREDIT_W'({pi_money_one, pi_money_half});
  assign credit_sum = po_credit + coin_add;
  assign credit_rem = po_credit - PRICE_C;

`ifndef DSP_TIMEOUT_EN
  assign po_fault = 1'b0;
`endif

  // Transaction FSM; all outputs are registered here, credit lives in po_credit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      po_credit  <= '0;
      po_dsp_req <= 1'b0;
      po_change  <= 1'b0;
      po_reject  <= 1'b0;
      to_cnt     <= '0;
      chg_cnt    <= '0;
`ifdef DSP_TIMEOUT_EN
      po_fault   <= 1'b0;
`endif
    end else begin
      po_change <= 1'b0;
      po_reject <= 1'b0;
      unique case (state)
        IDLE: begin
          if (coin_in) begin
            po_credit <= coin_add;
            to_cnt    <= '0;
            if (coin_add >= PRICE_C) begin
              state      <= DISPENSE;
              po_dsp_req <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
        end

        COLLECT: begin
          po_credit <= credit_sum;
          if (coin_in) begin
            to_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
          if (pi_cancel) begin
            state   <= REFUND;
            chg_cnt <= '0;
          end else if (credit_sum >= PRICE_C) begin
            state      <= DISPENSE;
            po_dsp_req <= 1'b1;
            to_cnt     <= '0;
          end else if (!coin_in && (to_cnt == TO_LAST)) begin
            state   <= REFUND;
            chg_cnt <= '0;
          end
        end

        DISPENSE: begin
          if (coin_in) begin
            po_reject <= 1'b1;
          end
          if (pi_dsp_ack) begin
            po_dsp_req <= 1'b0;
            po_credit  <= credit_rem;
            chg_cnt    <= '0;
            state      <= (credit_rem != '0) ? REFUND : IDLE;
          end
`ifdef DSP_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            po_dsp_req <= 1'b0;
            po_fault   <= 1'b1;
            chg_cnt    <= '0;
            state      <= REFUND;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end

        REFUND: begin
          if (coin_in) begin
            po_reject <= 1'b1;
          end
          if (po_credit == '0) begin
            state <= IDLE;
          end else if (chg_cnt == '0) begin
            po_change <= 1'b1;
            po_credit <= po_credit - CREDIT_W'(1);
            chg_cnt   <= GAP_LAST;
            if (po_credit == CREDIT_W'(1)) begin
              state <= IDLE;
            end
          end else begin
            chg_cnt <= chg_cnt - GAP_W'(1);
          end
        end

        default: begin
          state      <= IDLE;
          po_dsp_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed self-checking bench for vend_ctrl.
// Change/reject pulses are predicted into scoreboard queues when stimulus is
// driven and matched by a negedge monitor; levels are checked directly.
// Honors DSP_TIMEOUT_EN when the build defines it.
module tb_vend_ctrl;

  localparam int PRICE       = 4;
  localparam int CREDIT_W    = 3;
  localparam int CHG_GAP     = 8;
  localparam int TIMEOUT_CYC = 20;
  localparam int TO_W        = 26;

  logic                sys_clk;
  logic                sys_rst_n;
  logic                pi_money_half;
  logic                pi_money_one;
  logic                pi_cancel;
  logic                pi_dsp_ack;
  logic                po_dsp_req;
  logic                po_change;
  logic                po_reject;
  logic [CREDIT_W-1:0] po_credit;
  logic                po_fault;

  typedef struct {
    int cyc;
    int credit;
  } chg_t;

  chg_t chg_q[$];
  int   rej_q[$];
  chg_t mon_e;
  int   mon_r;
  int   cyc;
  int   n_assert;
  int   n_fail;
  int   base;

  vend_ctrl #(
    .PRICE(PRICE),
    .CREDIT_W(CREDIT_W),
    .CHG_GAP(CHG_GAP),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W(TO_W)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .pi_money_half(pi_money_half),
    .pi_money_one(pi_money_one),
    .pi_cancel(pi_cancel),
    .pi_dsp_ack(pi_dsp_ack),
    .po_dsp_req(po_dsp_req),
    .po_change(po_change),
    .po_reject(po_reject),
    .po_credit(po_credit),
    .po_fault(po_fault)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Cycle stamp used to time-tag predicted pulses.
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Global time limit so the run always ends.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic half, input logic one, input logic cancel);
    pi_money_half = half;
    pi_money_one  = one;
    pi_cancel     = cancel;
    @(posedge sys_clk);
    #1;
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cancel     = 1'b0;
  endtask

  task automatic doAck();
    pi_dsp_ack = 1'b1;
    @(posedge sys_clk);
    #1;
    pi_dsp_ack = 1'b0;
  endtask

  task automatic pushChange(input int at_cyc, input int credit_after);
    chg_t e;
    e.cyc    = at_cyc;
    e.credit = credit_after;
    chg_q.push_back(e);
  endtask

  // Scoreboard monitor: match every change/reject pulse against predictions.
  always @(negedge sys_clk) begin
    if (po_change === 1'b1) begin
      checkOutput("change_expected", 32'(chg_q.size() > 0), 32'd1);
      if (chg_q.size() > 0) begin
        mon_e = chg_q.pop_front();
        checkOutput("change_cycle", cyc, mon_e.cyc);
        checkOutput("change_credit", 32'(po_credit), mon_e.credit);
      end
    end else if (chg_q.size() > 0 && cyc >= chg_q[0].cyc) begin
      mon_e = chg_q.pop_front();
      checkOutput("change_missing", 32'(po_change), 32'd1);
    end
    if (po_reject === 1'b1) begin
      checkOutput("reject_expected", 32'(rej_q.size() > 0), 32'd1);
      if (rej_q.size() > 0) begin
        mon_r = rej_q.pop_front();
        checkOutput("reject_cycle", cyc, mon_r);
      end
    end else if (rej_q.size() > 0 && cyc >= rej_q[0]) begin
      mon_r = rej_q.pop_front();
      checkOutput("reject_missing", 32'(po_reject), 32'd1);
    end
  end

  // Directed test sequence.
  initial begin
    cyc           = 0;
    n_assert      = 0;
    n_fail        = 0;
    sys_rst_n     = 1'b0;
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cancel     = 1'b0;
    pi_dsp_ack    = 1'b0;

    #12;
    checkOutput("rst_credit", 32'(po_credit), 32'd0);
    checkOutput("rst_req", 32'(po_dsp_req), 32'd0);
    checkOutput("rst_change", 32'(po_change), 32'd0);
    checkOutput("rst_reject", 32'(po_reject), 32'd0);
    checkOutput("rst_fault", 32'(po_fault), 32'd0);
    #10;
    sys_rst_n = 1'b1;
    tick(1);

    $display("[TB] four half coins then exact vend");
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t1_credit", 32'(po_credit), 32'(i));
      checkOutput("t1_req", 32'(po_dsp_req), (i == 4) ? 32'd1 : 32'd0);
      if (i < 4) tick(2);
    end
    tick(4);
    doAck();
    checkOutput("t1_req_drop", 32'(po_dsp_req), 32'd0);
    checkOutput("t1_credit_end", 32'(po_credit), 32'd0);
    tick(12);

    $display("[TB] half, one, one then change of one half");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t2_credit_a", 32'(po_credit), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t2_credit_b", 32'(po_credit), 32'd3);
    checkOutput("t2_req_b", 32'(po_dsp_req), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t2_credit_c", 32'(po_credit), 32'd5);
    checkOutput("t2_req_c", 32'(po_dsp_req), 32'd1);
    tick(2);
    pushChange(cyc + 2, 0);
    doAck();
    checkOutput("t2_req_drop", 32'(po_dsp_req), 32'd1 - 32'd1);
    checkOutput("t2_remainder", 32'(po_credit), 32'd1);
    tick(12);
    checkOutput("t2_credit_end", 32'(po_credit), 32'd0);

    $display("[TB] one then cancel");
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushChange(cyc + 2, 1);
    pushChange(cyc + 2 + CHG_GAP, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t3_credit", 32'(po_credit), 32'd2);
    tick(CHG_GAP + 4);
    checkOutput("t3_credit_end", 32'(po_credit), 32'd0);
    checkOutput("t3_req", 32'(po_dsp_req), 32'd0);

    $display("[TB] coin and cancel in the same cycle");
    applyStimulus(1'b1, 1'b0, 1'b0);
    pushChange(cyc + 2, 2);
    pushChange(cyc + 2 + CHG_GAP, 1);
    pushChange(cyc + 2 + 2 * CHG_GAP, 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t3b_credit", 32'(po_credit), 32'd3);
    tick(2 * CHG_GAP + 4);
    checkOutput("t3b_credit_end", 32'(po_credit), 32'd0);

    $display("[TB] cancel while idle is ignored");
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(3);
    checkOutput("idle_cancel_credit", 32'(po_credit), 32'd0);

    $display("[TB] inactivity timeout refund");
    pushChange(cyc + 1 + TIMEOUT_CYC + 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t4_credit", 32'(po_credit), 32'd1);
    tick(TIMEOUT_CYC - 1);
    checkOutput("t4_credit_wait", 32'(po_credit), 32'd1);
    tick(3);
    checkOutput("t4_credit_end", 32'(po_credit), 32'd0);

    $display("[TB] coins and cancel during dispense");
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t5_credit_a", 32'(po_credit), 32'd3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    base = cyc;
    checkOutput("t5_req", 32'(po_dsp_req), 32'd1);
    checkOutput("t5_credit_b", 32'(po_credit), 32'd4);
    rej_q.push_back(cyc + 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t5_credit_rej", 32'(po_credit), 32'd4);
    checkOutput("t5_req_rej", 32'(po_dsp_req), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t5_req_cancel", 32'(po_dsp_req), 32'd1);
`ifdef DSP_TIMEOUT_EN
    for (int k = 0; k < 4; k++) pushChange(base + TIMEOUT_CYC + 1 + k * CHG_GAP, 3 - k);
    while (cyc < base + TIMEOUT_CYC - 1) tick(1);
    checkOutput("t5_req_before_wd", 32'(po_dsp_req), 32'd1);
    checkOutput("t5_fault_before_wd", 32'(po_fault), 32'd0);
    tick(1);
    checkOutput("t5_req_wd", 32'(po_dsp_req), 32'd0);
    checkOutput("t5_fault_wd", 32'(po_fault), 32'd1);
    checkOutput("t5_credit_wd", 32'(po_credit), 32'd4);
    while (cyc < base + TIMEOUT_CYC + 2 + 3 * CHG_GAP) tick(1);
    checkOutput("t5_credit_refunded", 32'(po_credit), 32'd0);
    checkOutput("t5_fault_sticky", 32'(po_fault), 32'd1);
`else
    while (cyc < base + TIMEOUT_CYC + 10) tick(1);
    checkOutput("t5_req_wait", 32'(po_dsp_req), 32'd1);
    checkOutput("t5_fault_wait", 32'(po_fault), 32'd0);
    checkOutput("t5_credit_wait", 32'(po_credit), 32'd4);
    doAck();
    checkOutput("t5_req_drop", 32'(po_dsp_req), 32'd0);
    checkOutput("t5_credit_end", 32'(po_credit), 32'd0);
`endif
    tick(4);

    $display("[TB] reset in the middle of a refund");
    applyStimulus(1'b1, 1'b0, 1'b0);
    pushChange(cyc + 2, 2);
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick(3);
    checkOutput("t6_credit_mid", 32'(po_credit), 32'd2);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_credit", 32'(po_credit), 32'd0);
    checkOutput("t6_rst_req", 32'(po_dsp_req), 32'd0);
    checkOutput("t6_rst_change", 32'(po_change), 32'd0);
    checkOutput("t6_rst_fault", 32'(po_fault), 32'd0);
    tick(2);
    #2;
    sys_rst_n = 1'b1;
    tick(20);
    checkOutput("t6_credit_after", 32'(po_credit), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t6_idle_accepts", 32'(po_credit), 32'd1);
    pushChange(cyc + 2, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick(4);
    checkOutput("t6_credit_end", 32'(po_credit), 32'd0);

    tick(2);
    checkOutput("change_queue_drained", 32'(chg_q.size()), 32'd0);
    checkOutput("reject_queue_drained", 32'(rej_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
